sq_cbrt_sum: RTL and testbench
==============================

SQ_CBRT_SUM -- requirements
Module: sq_cbrt_sum

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning operand width; only 8 is supported.
REQ-002 SHALL have port clk_i, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, meaning reset; asynchronous, active-high.
REQ-004 SHALL have port start_i, input, 1, meaning request: operands are valid on this cycle.
REQ-005 SHALL have port a_bi, input, 8, meaning unsigned operand a, which is squared.
REQ-006 SHALL have port b_bi, input, 8, meaning unsigned operand b, whose integer cube root is taken.
REQ-007 SHALL have port busy_o, output, 2, meaning computation in progress; bit 0 carries the flag, bit 1 is tied to 0.
REQ-008 SHALL have port y_bo, output, 16, meaning result a*a + floor(cbrt(b)).

Function
REQ-009 SHALL compute y_bo = a^2 + floor(cbrt(b)), unsigned; maximum value is 65025+6=65031, so no overflow in 16 bits.
REQ-010 SHALL use the states IDLE, LAUNCH, RUN, SUM.
REQ-011 IDLE: busy_o=0; on start_i=1, SHALL latch a_bi/b_bi into internal registers and move to LAUNCH.
REQ-012 LAUNCH (1 cycle): SHALL drive a one-cycle start pulse to the cbrt instance with the latched b, and start the squaring multiplier with the latched a; next state RUN.
REQ-013 RUN: the multiplier SHALL be shift-add, one multiplier bit per cycle, 8 cycles; cbrt runs concurrently.
REQ-014 RUN SHALL NOT sample cbrt busy in the first RUN cycle, because cbrt busy rises one cycle after its start pulse.
REQ-015 SHALL leave RUN for SUM on the first cycle where the multiplier is done and cbrt busy = 0; either unit may finish first, and the finished result is held.
REQ-016 SUM (1 cycle): SHALL register y_bo = square + zero-extended cbrt result; next state IDLE.
REQ-017 busy_o[0] SHALL be 1 from the cycle after start_i is accepted through the SUM cycle inclusive; it falls together with the y_bo update.
REQ-018 y_bo SHALL hold the last result until the next SUM; it SHALL NOT change in any other state.
REQ-019 start_i while not in IDLE SHALL be ignored; operands are not relatched.
REQ-020 a=0 or b=0 SHALL produce correct results (0 square / 0 root), with the same state sequence and no shortcut.
REQ-021 Latency from start accept to result SHALL be 1 (LAUNCH) + max(8, cbrt latency + 1) + 1 (SUM) cycles.

Reset
REQ-022 rst_i=1 SHALL asynchronously force state=IDLE, busy_o=0, y_bo=0, and clear the operand registers, multiplier accumulator and counter.
REQ-023 rst_i SHALL be wired directly to the cbrt instance reset; reset mid-operation aborts both units with no residual start pulse.
REQ-024 After rst_i deasserts, the first start_i SHALL be accepted normally.

Structure
REQ-025 The shared package SHALL hold the state enum (IDLE/LAUNCH/RUN/SUM), operand width 8, result width 16 and multiplier iteration count 8.
REQ-026 The block SHALL instantiate the existing cbrt module unchanged, connecting clk_i, rst_i, a_bi, start_i, busy_o and y_bo.
REQ-027 The shift-add squarer SHALL be the single new sub-module, mul_sa, with clk_i, rst_i, start_i, a_bi, b_bi, busy_o and y_bo[15:0].
REQ-028 The top SHALL contain only the FSM, the operand registers and the 16-bit adder.

Verification
REQ-029 The bench SHALL drive a=3, b=8 -> y_bo=11, busy_o returns to 0.
REQ-030 The bench SHALL drive a=10, b=200 -> y_bo=105; then a=0, b=0 -> y_bo=0.
REQ-031 The bench SHALL drive a=255, b=255 -> y_bo=65031 (no wrap); then a=1, b=1 -> y_bo=2.
REQ-032 The bench SHALL start a=4, b=68, then pulse start_i with a=9, b=27 mid-run -> y_bo=20; the second request is ignored.
REQ-033 The bench SHALL start a=7, b=125, assert rst_i in RUN -> busy_o=0 and y_bo=0 immediately; a following a=2, b=9 -> y_bo=6.
REQ-034 The bench SHALL check busy_o[0] every cycle against the REQ-021 latency for a=5, b=125 (y_bo=30), and check y_bo is stable while busy.

Source files
------------

// File: rtl/sq_cbrt_sum_pkg.sv
// Shared definitions for the square-plus-cube-root block: FSM states and
// datapath widths.
package sq_cbrt_sum_pkg;

  localparam int unsigned OPER_W   = 8;
  localparam int unsigned RESULT_W = 16;
  localparam int unsigned MUL_ITER = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    SUM    = 2'd3
  } state_t;

endpackage

// File: rtl/cbrt.sv
// Integer cube root of an 8-bit unsigned value, one result bit-group per cycle.
// busy_o rises the cycle after start_i and the root is valid once it falls.
module cbrt (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] a_bi,
  input  logic       start_i,
  output logic       busy_o,
  output logic [7:0] y_bo
);

  logic [7:0]  x_r;
  logic [7:0]  y_r;
  logic [1:0]  step_r;
  logic        busy_r;
  logic [15:0] y2w;
  logic [15:0] term;
  logic [3:0]  shamt;
  logic        ge;

  // Digit recurrence over shifts 6, 3, 0: try y' = 2y+1 against the remainder.
  always_comb begin
    y2w   = '0;
    term  = '0;
    shamt = '0;
    ge    = 1'b0;
    case (step_r)
      2'd0:    shamt = 4'd6;
      2'd1:    shamt = 4'd3;
      default: shamt = 4'd0;
    endcase
    y2w  = {7'b0, y_r, 1'b0};
    term = ((y2w * (y2w + 16'd1)) * 16'd3 + 16'd1) << shamt;
    ge   = ({8'b0, x_r} >= term);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_r    <= '0;
      y_r    <= '0;
      step_r <= '0;
      busy_r <= 1'b0;
    end else if (!busy_r) begin
      if (start_i) begin
        x_r    <= a_bi;
        y_r    <= '0;
        step_r <= '0;
        busy_r <= 1'b1;
      end
    end else begin
      if (ge) begin
        x_r <= x_r - term[7:0];
        y_r <= y2w[7:0] + 8'd1;
      end else begin
        y_r <= y2w[7:0];
      end
      if (step_r == 2'd2) begin
        busy_r <= 1'b0;
      end else begin
        step_r <= step_r + 2'd1;
      end
    end
  end

  assign busy_o = busy_r;
  assign y_bo   = y_r;

endmodule

// File: rtl/mul_sa.sv
// Shift-add 8x8 unsigned multiplier, one multiplier bit per cycle.
module mul_sa
  import sq_cbrt_sum_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  a_bi,
  input  logic [7:0]  b_bi,
  output logic        busy_o,
  output logic [15:0] y_bo
);

  logic [15:0] acc_r;
  logic [15:0] mcand_r;
  logic [7:0]  mplier_r;
  logic [3:0]  cnt_r;

  // Bit 0 is folded into the load edge so all eight bits finish in eight edges.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_r    <= '0;
      mcand_r  <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
    end else if (start_i) begin
      acc_r    <= b_bi[0] ? {8'b0, a_bi} : '0;
      mcand_r  <= {7'b0, a_bi, 1'b0};
      mplier_r <= {1'b0, b_bi[7:1]};
      cnt_r    <= 4'(MUL_ITER - 1);
    end else if (cnt_r != '0) begin
      if (mplier_r[0]) begin
        acc_r <= acc_r + mcand_r;
      end
      mcand_r  <= {mcand_r[14:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[7:1]};
      cnt_r    <= cnt_r - 4'd1;
    end
  end

  assign busy_o = (cnt_r != '0);
  assign y_bo   = acc_r;

endmodule

// File: rtl/sq_cbrt_sum.sv
// y = a*a + floor(cbrt(b)): control FSM, operand registers and final adder
// around a shift-add squarer and the cube-root unit.
module sq_cbrt_sum #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] a_bi,
  input  logic [DATA_W-1:0] b_bi,
  output logic [1:0]        busy_o,
  output logic [15:0]       y_bo
);
  import sq_cbrt_sum_pkg::*;

  state_t              state_r;
  logic [DATA_W-1:0]   a_r;
  logic [DATA_W-1:0]   b_r;
  logic                first_run_r;
  logic [RESULT_W-1:0] y_r;
  logic                launch;
  logic                mul_busy;
  logic [15:0]         square;
  logic                cbrt_busy;
  logic [7:0]          root;

  assign launch = (state_r == LAUNCH);

  mul_sa u_mul (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (launch),
    .a_bi    (a_r),
    .b_bi    (a_r),
    .busy_o  (mul_busy),
    .y_bo    (square)
  );

  cbrt u_cbrt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .a_bi    (b_r),
    .start_i (launch),
    .busy_o  (cbrt_busy),
    .y_bo    (root)
  );

  // cbrt busy lags its start pulse, so the first RUN cycle must not trust it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      first_run_r <= 1'b0;
      y_r         <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_i) begin
            a_r     <= a_bi;
            b_r     <= b_bi;
            state_r <= LAUNCH;
          end
        end
        LAUNCH: begin
          first_run_r <= 1'b1;
          state_r     <= RUN;
        end
        RUN: begin
          first_run_r <= 1'b0;
          if (!first_run_r && !mul_busy && !cbrt_busy) begin
            state_r <= SUM;
          end
        end
        default: begin
          y_r     <= square + {8'b0, root};
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = {1'b0, (state_r != IDLE)};
  assign y_bo   = y_r;

endmodule

// File: tb/tb_sq_cbrt_sum.sv
// Directed bench for sq_cbrt_sum: vector table plus start-ignore, reset-abort
// and cycle-by-cycle busy sequences.
module tb_sq_cbrt_sum;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  a_bi;
  logic [7:0]  b_bi;
  logic [1:0]  busy_o;
  logic [15:0] y_bo;

  int errors = 0;
  int checks = 0;

  localparam int LATENCY = 10;
  localparam int MAX_WAIT = 40;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] y;
  } vec_t;

  vec_t vecs[6];

  sq_cbrt_sum #(.DATA_W(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .a_bi    (a_bi),
    .b_bi    (b_bi),
    .busy_o  (busy_o),
    .y_bo    (y_bo)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and return the number of edges until busy falls.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk_i);
    a_bi    = a;
    b_bi    = b;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    lat = 0;
    while (busy_o[0] && lat < MAX_WAIT) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [15:0] held;

    vecs[0] = '{a: 8'd3,   b: 8'd8,   y: 16'd11};
    vecs[1] = '{a: 8'd10,  b: 8'd200, y: 16'd105};
    vecs[2] = '{a: 8'd0,   b: 8'd0,   y: 16'd0};
    vecs[3] = '{a: 8'd255, b: 8'd255, y: 16'd65031};
    vecs[4] = '{a: 8'd1,   b: 8'd1,   y: 16'd2};
    vecs[5] = '{a: 8'd12,  b: 8'd64,  y: 16'd148};

    rst_i   = 1'b1;
    start_i = 1'b0;
    a_bi    = '0;
    b_bi    = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_busy", int'(busy_o), 0);
    check("reset_y", int'(y_bo), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("vec%0d_y", i), int'(y_bo), int'(vecs[i].y));
      check($sformatf("vec%0d_latency", i), lat, LATENCY);
      check($sformatf("vec%0d_busy_hi_bit", i), int'(busy_o[1]), 0);
    end

    // Start while running must be ignored.
    @(negedge clk_i);
    a_bi = 8'd4; b_bi = 8'd68; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    a_bi = 8'd9; b_bi = 8'd27; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    lat = 0;
    while (busy_o[0] && lat < MAX_WAIT) begin
      @(posedge clk_i);
      #1;
      lat++;
    end
    check("ignore_y", int'(y_bo), 20);
    check("ignore_latency_rest", lat, LATENCY - 4);
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    check("ignore_no_restart", int'(busy_o), 0);

    // Reset in the middle of RUN aborts immediately.
    @(negedge clk_i);
    a_bi = 8'd7; b_bi = 8'd125; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (3) begin
      @(posedge clk_i);
      #1;
    end
    check("pre_reset_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    check("abort_busy", int'(busy_o), 0);
    check("abort_y", int'(y_bo), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("post_reset_idle", int'(busy_o), 0);
    do_op(8'd2, 8'd9, lat);
    check("post_reset_y", int'(y_bo), 6);
    check("post_reset_latency", lat, LATENCY);

    // Cycle-by-cycle busy profile and output stability.
    held = y_bo;
    @(negedge clk_i);
    a_bi = 8'd5; b_bi = 8'd125; start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    for (int k = 0; k <= LATENCY; k++) begin
      check($sformatf("profile_busy_c%0d", k), int'(busy_o), (k < LATENCY) ? 1 : 0);
      if (k < LATENCY) begin
        check($sformatf("profile_hold_c%0d", k), int'(y_bo), int'(held));
        @(posedge clk_i);
        #1;
      end
    end
    check("profile_y", int'(y_bo), 30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
